pkt_tx_ctrl: RTL and testbench
==============================

# pkt_tx_ctrl

Output-side packet transmitter that drains the synchronous packet FIFO of a router port and forwards whole packets onto the output channel. It sits between the FIFO read port (`data_out`/`pop`/`empty`) and the output link. Its input is a commit pulse that the receive path raises once a CRC-checked packet is completely written. The block never starts a packet that is not fully committed, so a flushed (bad-CRC) packet is never visible downstream. Data passes through with zero latency under a valid/ready handshake, with start- and end-of-packet markers.

## Interface
- `DATA_WIDTH`, 8: byte width of FIFO and output channel.
- `LEN_WIDTH`, 6: width of the payload-length field in the header byte, bits [LEN_WIDTH-1:0]. Must be ≤ `DATA_WIDTH`.
- `CNT_WIDTH`, 4: width of the committed-packet counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `fifo_data`  in  DATA_WIDTH  FIFO head byte, combinationally valid while `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_pop`  out  1  pop request; advances the FIFO read pointer.
- `pkt_commit`  in  1  one-cycle pulse: one more complete, good packet is now in the FIFO.
- `tx_data`  out  DATA_WIDTH  output byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  downstream accepts the byte.
- `tx_sop`  out  1  qualifies the header byte; meaningful only with `tx_valid`.
- `tx_eop`  out  1  qualifies the last (CRC) byte; meaningful only with `tx_valid`.
- `pkt_cnt`  out  CNT_WIDTH  number of committed packets not yet fully sent.
- `busy`  out  1  state ≠ IDLE.
- `cnt_ovf`  out  1  sticky: a commit arrived while `pkt_cnt` was at its maximum.

## Operation
- Packet format: header byte (length L = header[LEN_WIDTH-1:0]), then L payload bytes, then 1 CRC byte. Total length is L+2 bytes; L=0 is legal (2 bytes).
- Handshake: `hs` = `tx_valid` & `tx_ready`. `tx_data` = `fifo_data`. `tx_valid` = (state ∈ {HDR, BODY}) & !`fifo_empty`. `fifo_pop` = `hs`.
- `tx_valid` must not depend on `tx_ready`. Once asserted, `tx_valid` and `tx_data` hold until `hs`.
- Counter: `pkt_cnt` increments on `pkt_commit` and decrements on (`hs` & `tx_eop`). If both happen in the same cycle, it is unchanged.
- A commit at all-ones is dropped, and `cnt_ovf` is set and held until reset.
- A decrement at 0 cannot occur, because HDR is only entered with `pkt_cnt` > 0.
- State machine:
  - IDLE: `tx_valid`=0. Go to HDR when `pkt_cnt` ≠ 0.
  - HDR: `tx_sop`=1. On `hs`, latch `rem` = L+1 (LEN_WIDTH+1 bits, so no overflow at L = 2^LEN_WIDTH-1) and go to BODY.
  - BODY: `tx_eop` = (`rem`==1). On `hs`, decrement `rem`. On `hs` with `tx_eop`=1, go to HDR if the next-cycle `pkt_cnt` ≠ 0, else IDLE.
- `fifo_empty` while in HDR/BODY (underrun, which should not occur once committed): stall with `tx_valid`=0. No error is raised; the packet resumes when data appears.
- `busy` is high in HDR and BODY.

## Timing
- Reset values: state IDLE, `tx_valid` 0, `tx_sop` 0, `tx_eop` 0, `fifo_pop` 0, `pkt_cnt` 0, `busy` 0, `cnt_ovf` 0, `rem` 0.
- Reset asserted mid-packet aborts the packet immediately. The FIFO is reset by the same `rst_n`.
- Latency:
  - `pkt_commit` at cycle N → `pkt_cnt` updates at N+1 → state HDR at N+2, with `tx_valid` high in N+2 if the FIFO is not empty.
  - Back-to-back packets need no idle cycle: the header of packet k+1 may handshake the cycle after the eop of packet k.
- Full throughput: with `tx_ready` held at 1, a packet of length L occupies exactly L+2 consecutive cycles.
- `tx_ready` low stalls with no byte lost or duplicated. `fifo_pop` is only ever high with `fifo_empty`=0.

## Test plan
- Single packet, header 0x03, payload 0xA1 0xA2 0xA3, CRC 0x5C, `tx_ready`=1, one commit → bytes 03,A1,A2,A3,5C on 5 consecutive cycles; sop on 03 only, eop on 5C only; `pkt_cnt` 1→0; `busy` 1→0 afterwards.
- Zero-length packet (header 0x00, CRC 0x7E) → 2 bytes, sop then eop. Max-length packet (L=63) → 65 bytes, eop on byte 65 only.
- Three committed packets of L=1 with `tx_ready`=1 → 9 consecutive valid cycles; no bubble between eop and the next sop; `pkt_cnt` ends at 0.
- `tx_ready` toggling 1,0,0,1,0,1… during an L=4 packet → output byte sequence is identical to the unstalled case; `fifo_pop` count is 6; `tx_data` is stable across stall cycles.
- Bytes present in the FIFO but no `pkt_commit` (partial packet) → `tx_valid` stays 0 for ≥20 cycles. Then `pkt_commit` coincides with the eop handshake of a previous packet → `pkt_cnt` unchanged and the next header is sent immediately.
- 16 commits with no draining (CNT_WIDTH=4) → `pkt_cnt`=15 and `cnt_ovf`=1 sticky. Assert `rst_n`=0 mid-packet → all outputs 0 asynchronously; `cnt_ovf` clears.

Source files
------------

// File: rtl/pkt_tx_ctrl.sv
`timescale 1ns/1ps
// Output-side packet transmitter: forwards only fully committed packets from the
// port FIFO onto the output link, with zero-latency valid/ready and sop/eop flags.
module pkt_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 6,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic                  pkt_commit,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  busy,
  output logic                  cnt_ovf
);

  // rem counts payload + CRC bytes still to send; one extra bit covers L = max
  localparam int unsigned REM_WIDTH = LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t               state;
  logic [REM_WIDTH-1:0] rem;
  logic [REM_WIDTH-1:0] hdr_rem;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 hs;
  logic                 pkt_done;
  logic                 cnt_full;
  logic                 ovf_set;

  // Data path is a straight pass-through of the FIFO head
  assign tx_data  = fifo_data;
  assign tx_valid = ((state == HDR) || (state == BODY)) && !fifo_empty;
  assign hs       = tx_valid && tx_ready;
  assign fifo_pop = hs;
  assign tx_sop   = (state == HDR);
  assign tx_eop   = (state == BODY) && (rem == REM_WIDTH'(1));
  assign busy     = (state != IDLE);
  assign pkt_done = hs && tx_eop;
  assign cnt_full = &pkt_cnt;
  assign hdr_rem  = REM_WIDTH'(fifo_data[LEN_WIDTH-1:0]) + REM_WIDTH'(1);

  // Committed-packet count: a commit and a finished packet in one cycle cancel
  always_comb begin
    cnt_nxt = pkt_cnt;
    ovf_set = 1'b0;
    if (pkt_commit && !pkt_done) begin
      if (cnt_full) begin
        ovf_set = 1'b1;
      end else begin
        cnt_nxt = pkt_cnt + CNT_WIDTH'(1);
      end
    end else if (!pkt_commit && pkt_done) begin
      cnt_nxt = pkt_cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      cnt_ovf <= 1'b0;
    end else begin
      pkt_cnt <= cnt_nxt;
      if (ovf_set) begin
        cnt_ovf <= 1'b1;
      end
    end
  end

  // Packet framing FSM; HDR is entered only with at least one committed packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_cnt != '0) begin
            state <= HDR;
          end
        end
        HDR: begin
          if (hs) begin
            rem   <= hdr_rem;
            state <= BODY;
          end
        end
        BODY: begin
          if (hs) begin
            rem <= rem - REM_WIDTH'(1);
            if (tx_eop) begin
              state <= (cnt_nxt != '0) ? HDR : IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pkt_tx_ctrl: directed vector table, multi-cycle corner
// sequences and random traffic against a packet-level reference model.
module tb_pkt_tx_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 6;
  localparam int unsigned CW = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          pkt_commit;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_sop;
  logic          tx_eop;
  logic [CW-1:0] pkt_cnt;
  logic          busy;
  logic          cnt_ovf;

  pkt_tx_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .pkt_commit(pkt_commit), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .pkt_cnt(pkt_cnt), .busy(busy), .cnt_ovf(cnt_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct {
    logic       commit;
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;

  logic [7:0] fq[$];
  beat_t      stage_q[$];
  beat_t      exp_q[$];
  logic [7:0] rx_d[$];
  logic       rx_sop[$];
  logic       rx_eop[$];
  int         rx_cyc[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  int   m_cnt = 0;
  logic m_ovf = 1'b0;
  bit   chk_stream = 1'b1;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic       s_valid, s_sop, s_eop, s_pop, s_busy, s_empty, s_ready, s_commit;
  logic [7:0] s_data;
  logic [3:0] s_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc_n);
    end
  endtask

  function automatic beat_t gen_beat(input int i, input int len, input logic [1:0] hi,
                                     input logic [7:0] base);
    beat_t b;
    b.sop = (i == 0);
    b.eop = (i == len + 1);
    if (i == 0)             b.d = {hi, 6'(len)};
    else if (i == len + 1)  b.d = base ^ 8'h5A;
    else                    b.d = base + 8'(i);
    return b;
  endfunction

  task automatic push_beat(input beat_t b);
    fq.push_back(b.d);
    stage_q.push_back(b);
  endtask

  task automatic push_pkt(input int len, input logic [1:0] hi, input logic [7:0] base);
    for (int i = 0; i < len + 2; i++) push_beat(gen_beat(i, len, hi, base));
  endtask

  // A good commit makes the oldest staged packet eligible for transmission
  function automatic void commit_model();
    beat_t b;
    while (stage_q.size() > 0) begin
      b = stage_q.pop_front();
      exp_q.push_back(b);
      if (b.eop) break;
    end
  endfunction

  // One clock: drive FIFO head, sample before the edge, update models after it
  task automatic cyc();
    logic hs;
    logic dec;
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fq[0];
    #1;
    s_valid = tx_valid; s_data = tx_data; s_sop = tx_sop; s_eop = tx_eop;
    s_pop = fifo_pop; s_busy = busy; s_cnt = pkt_cnt; s_empty = fifo_empty;
    s_ready = tx_ready; s_commit = pkt_commit;
    hs = s_valid & s_ready;
    check("pop_eq_hs", 32'(s_pop), 32'(hs));
    if (s_pop) check("pop_nonempty", 32'(s_empty), 32'd0);
    dec = 1'b0;
    if (chk_stream) begin
      if (prev_stall) begin
        check("stall_valid", 32'(s_valid), 32'd1);
        check("stall_data", 32'(s_data), 32'(prev_data));
      end
      if (s_valid) check("valid_committed", 32'(exp_q.size() > 0), 32'd1);
      if (hs && exp_q.size() > 0) begin
        check("rx_data", 32'(s_data), 32'(exp_q[0].d));
        check("rx_sop", 32'(s_sop), 32'(exp_q[0].sop));
        check("rx_eop", 32'(s_eop), 32'(exp_q[0].eop));
        dec = exp_q[0].eop;
        void'(exp_q.pop_front());
      end
    end else begin
      dec = hs & s_eop;
    end
    if (hs) begin
      rx_d.push_back(s_data); rx_sop.push_back(s_sop);
      rx_eop.push_back(s_eop); rx_cyc.push_back(cyc_n);
    end
    prev_stall = s_valid & ~s_ready;
    prev_data  = s_data;
    @(posedge clk);
    cyc_n++;
    if (s_pop && fq.size() > 0) void'(fq.pop_front());
    if (s_commit && !dec) begin
      if (m_cnt == CNT_MAX) m_ovf = 1'b1;
      else begin m_cnt++; commit_model(); end
    end else if (s_commit && dec) begin
      commit_model();
    end else if (dec) begin
      m_cnt--;
    end
    #1;
    check("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
    check("cnt_ovf", 32'(cnt_ovf), 32'(m_ovf));
    @(negedge clk);
    pkt_commit = 1'b0;
  endtask

  task automatic clear_rx();
    rx_d.delete(); rx_sop.delete(); rx_eop.delete(); rx_cyc.delete();
  endtask

  task automatic collect(input int nbytes, input int budget, output bit ok);
    int c;
    c = 0;
    clear_rx();
    tx_ready = 1'b1;
    while (rx_d.size() < nbytes && c < budget) begin cyc(); c++; end
    ok = (rx_d.size() >= nbytes);
    check("collect_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain_all(input int budget);
    int c;
    c = 0;
    tx_ready = 1'b1;
    while ((exp_q.size() > 0 || m_cnt != 0) && c < budget) begin cyc(); c++; end
    check("drain_done", 32'(exp_q.size() == 0 && m_cnt == 0), 32'd1);
    cyc(); cyc();
    check("idle_busy", 32'(s_busy), 32'd0);
    check("idle_valid", 32'(s_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_sop"},   32'(tx_sop),   32'd0);
    check({tag, "_eop"},   32'(tx_eop),   32'd0);
    check({tag, "_pop"},   32'(fifo_pop), 32'd0);
    check({tag, "_busy"},  32'(busy),     32'd0);
    check({tag, "_cnt"},   32'(pkt_cnt),  32'd0);
    check({tag, "_ovf"},   32'(cnt_ovf),  32'd0);
  endtask

  task automatic model_reset();
    fq.delete(); stage_q.delete(); exp_q.delete(); clear_rx();
    m_cnt = 0; m_ovf = 1'b0; prev_stall = 1'b0; pkt_commit = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tv[9];
    beat_t      e4[6];
    logic [5:0] pat;
    bit         ok;
    int         pops, k, len, nsop, neop, uncommitted;
    beat_t      wr_q[$];
    beat_t      b;

    rst_n = 1'b0; pkt_commit = 1'b0; tx_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data = 8'h00;
    #1;
    check_reset_outputs("rst0");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single L=3 packet, cycle by cycle
    tv[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    tv[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1};
    tv[2] = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 4'd1};
    tv[3] = '{1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 4'd1};
    tv[4] = '{1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 4'd1};
    tv[5] = '{1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 4'd1};
    tv[6] = '{1'b0, 1'b1, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b1, 4'd1};
    tv[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    tv[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    push_beat('{8'h03, 1'b1, 1'b0});
    push_beat('{8'hA1, 1'b0, 1'b0});
    push_beat('{8'hA2, 1'b0, 1'b0});
    push_beat('{8'hA3, 1'b0, 1'b0});
    push_beat('{8'h5C, 1'b0, 1'b1});
    for (int i = 0; i < 9; i++) begin
      pkt_commit = tv[i].commit;
      tx_ready   = tv[i].ready;
      cyc();
      check($sformatf("t1_valid[%0d]", i), 32'(s_valid), 32'(tv[i].valid));
      if (tv[i].valid) begin
        check($sformatf("t1_data[%0d]", i), 32'(s_data), 32'(tv[i].data));
        check($sformatf("t1_sop[%0d]", i),  32'(s_sop),  32'(tv[i].sop));
        check($sformatf("t1_eop[%0d]", i),  32'(s_eop),  32'(tv[i].eop));
      end
      check($sformatf("t1_busy[%0d]", i), 32'(s_busy), 32'(tv[i].busy));
      check($sformatf("t1_cnt[%0d]", i),  32'(s_cnt),  32'(tv[i].cnt));
    end

    // Zero-length packet
    push_beat('{8'h00, 1'b1, 1'b0});
    push_beat('{8'h7E, 1'b0, 1'b1});
    pkt_commit = 1'b1;
    collect(2, 20, ok);
    if (ok) begin
      check("t2_b0", 32'(rx_d[0]), 32'h00);
      check("t2_sop0", 32'(rx_sop[0]), 32'd1);
      check("t2_eop0", 32'(rx_eop[0]), 32'd0);
      check("t2_b1", 32'(rx_d[1]), 32'h7E);
      check("t2_eop1", 32'(rx_eop[1]), 32'd1);
      check("t2_span", 32'(rx_cyc[1] - rx_cyc[0]), 32'd1);
    end
    drain_all(20);

    // Maximum-length packet, header upper bits set to confirm the length mask
    push_pkt(63, 2'b11, 8'h40);
    pkt_commit = 1'b1;
    collect(65, 200, ok);
    if (ok) begin
      nsop = 0; neop = 0;
      for (int i = 0; i < 65; i++) begin
        nsop += int'(rx_sop[i]);
        neop += int'(rx_eop[i]);
      end
      check("t2m_sop_count", 32'(nsop), 32'd1);
      check("t2m_eop_count", 32'(neop), 32'd1);
      check("t2m_eop_last", 32'(rx_eop[64]), 32'd1);
      check("t2m_span", 32'(rx_cyc[64] - rx_cyc[0]), 32'd64);
    end
    drain_all(20);

    // Three back-to-back L=1 packets
    push_pkt(1, 2'b00, 8'h10);
    push_pkt(1, 2'b01, 8'h20);
    push_pkt(1, 2'b10, 8'h30);
    tx_ready = 1'b1;
    pkt_commit = 1'b1; cyc();
    pkt_commit = 1'b1; cyc();
    pkt_commit = 1'b1;
    collect(9, 40, ok);
    if (ok) begin
      check("t3_span", 32'(rx_cyc[8] - rx_cyc[0]), 32'd8);
      for (int i = 0; i < 9; i++) begin
        check($sformatf("t3_sop[%0d]", i), 32'(rx_sop[i]), 32'((i % 3) == 0));
        check($sformatf("t3_eop[%0d]", i), 32'(rx_eop[i]), 32'((i % 3) == 2));
      end
    end
    drain_all(20);
    check("t3_cnt_end", 32'(s_cnt), 32'd0);

    // L=4 packet under tx_ready pattern 1,0,0,1,0,1 repeating
    push_pkt(4, 2'b00, 8'hB0);
    for (int i = 0; i < 6; i++) e4[i] = gen_beat(i, 4, 2'b00, 8'hB0);
    pat = 6'b101001;
    clear_rx();
    pops = 0; k = 0;
    pkt_commit = 1'b1;
    while (rx_d.size() < 6 && k < 100) begin
      tx_ready = pat[k % 6];
      cyc();
      pops += int'(s_pop);
      k++;
    end
    check("t4_pop_count", 32'(pops), 32'd6);
    if (rx_d.size() == 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("t4_byte[%0d]", i), 32'(rx_d[i]), 32'(e4[i].d));
    end
    drain_all(20);

    // Uncommitted bytes must not be sent; then commit on the eop handshake
    push_pkt(2, 2'b00, 8'hC0);
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("t5_hold_valid", 32'(s_valid), 32'd0);
    end
    check("t5_hold_busy", 32'(s_busy), 32'd0);
    pkt_commit = 1'b1; cyc();
    push_pkt(1, 2'b00, 8'hD0);
    cyc(); cyc(); cyc(); cyc();
    pkt_commit = 1'b1; cyc();
    check("t5_eop_hs", 32'(s_valid & s_ready & s_eop), 32'd1);
    check("t5_cnt_at_eop", 32'(s_cnt), 32'd1);
    cyc();
    check("t5_cnt_after", 32'(s_cnt), 32'd1);
    check("t5_next_sop", 32'(s_valid & s_sop), 32'd1);
    check("t5_next_hdr", 32'(s_data), 32'h01);
    drain_all(20);

    // Random traffic against the packet-level model
    uncommitted = 0;
    for (int t = 0; t < 4000; t++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if (wr_q.size() == 0 && uncommitted == 0 && m_cnt < 10 && $urandom_range(0, 2) == 0) begin
        len = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 6));
        b.d = 8'($urandom);
        for (int i = 0; i < len + 2; i++) wr_q.push_back(gen_beat(i, len, 2'($urandom), b.d));
        uncommitted = 1;
      end
      if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        b = wr_q.pop_front();
        push_beat(b);
      end else if (wr_q.size() == 0 && uncommitted != 0 && $urandom_range(0, 1) == 0) begin
        pkt_commit = 1'b1;
        uncommitted = 0;
      end
      cyc();
    end
    while (wr_q.size() > 0) begin b = wr_q.pop_front(); push_beat(b); end
    if (uncommitted != 0) pkt_commit = 1'b1;
    drain_all(2000);

    // Counter saturation, underrun stall, then asynchronous reset mid-packet
    chk_stream = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pkt_commit = 1'b1;
      cyc();
    end
    cyc();
    check("t6_cnt_sat", 32'(s_cnt), 32'd15);
    check("t6_ovf", 32'(cnt_ovf), 32'd1);
    check("t6_underrun_valid", 32'(s_valid), 32'd0);
    check("t6_underrun_busy", 32'(s_busy), 32'd1);
    cyc(); cyc();
    check("t6_ovf_sticky", 32'(cnt_ovf), 32'd1);
    fq.push_back(8'h05); fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    cyc();
    check("t6_resume_sop", 32'(s_valid & s_sop), 32'd1);
    cyc();
    check("t6_resume_body", 32'(s_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    model_reset();
    fifo_empty = 1'b1; fifo_data = 8'h00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk_stream = 1'b1;
    cyc(); cyc();
    check("t6_post_busy", 32'(s_busy), 32'd0);
    check("t6_post_cnt", 32'(s_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
